// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single 8-bit data memory port between the pipeline
// MEM stage (priority) and a DMA/debug port with a starvation guard, and runs
// a hardware zeroing sweep after reset or on clear_start.
// Optional build macro: DMEM_ARB_PERF_EN adds the stall_count output.
module dmem_arbiter #(
    parameter int ADDRESS_LINE = 8,
    parameter int MEM_SIZE     = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDRESS_LINE-1:0] cpu_addr,
    input  logic [7:0]              cpu_wdata,
    output logic [7:0]              cpu_rdata,
    output logic                    cpu_stall,
    input  logic                    dma_valid,
    input  logic                    dma_we,
    input  logic [ADDRESS_LINE-1:0] dma_addr,
    input  logic [7:0]              dma_wdata,
    output logic                    dma_ready,
    output logic                    dma_rvalid,
    output logic [7:0]              dma_rdata,
    input  logic                    clear_start,
    output logic                    clear_busy,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic [7:0]              mem_write_data,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [7:0]              mem_read_data
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]             stall_count
`endif
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDRESS_LINE-1:0] LAST_ADDR  = ADDRESS_LINE'(MEM_SIZE - 1);
    localparam logic [7:0]              STARVE_MAX = 8'(STARVE_LIMIT);

    state_t                  state_q, state_d;
    logic [ADDRESS_LINE-1:0] clr_addr_q, clr_addr_d;
    logic [7:0]              starve_cnt_q, starve_cnt_d;
    logic                    dma_rvalid_q, dma_rvalid_d;
    logic [7:0]              dma_rdata_q, dma_rdata_d;
    logic                    grant_cpu, grant_dma;

    // State register; reset always restarts the sweep.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_CLEAR;
        else       state_q <= state_d;
    end

    // Next state: sweep ends on the last address, clear_start re-enters the sweep.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
            ST_RUN:   if (clear_start) state_d = ST_CLEAR;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Outputs: grant decision and memory port mux.
    always_comb begin
        grant_dma      = 1'b0;
        grant_cpu      = 1'b0;
        cpu_stall      = 1'b0;
        dma_ready      = 1'b0;
        clear_busy     = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        cpu_rdata      = '0;
        case (state_q)
            ST_CLEAR: begin
                clear_busy  = 1'b1;
                cpu_stall   = cpu_req;
                mem_write   = 1'b1;
                mem_address = clr_addr_q;
            end
            ST_RUN: begin
                // DMA wins when the pipeline is idle or the DMA has waited long enough.
                grant_dma = dma_valid & (~cpu_req | (starve_cnt_q >= STARVE_MAX));
                grant_cpu = cpu_req & ~grant_dma;
                cpu_stall = cpu_req & ~grant_cpu;
                dma_ready = grant_dma;
                if (grant_dma) begin
                    mem_address    = dma_addr;
                    mem_write_data = dma_wdata;
                    mem_write      = dma_we;
                    mem_read       = ~dma_we;
                end else if (grant_cpu) begin
                    mem_address    = cpu_addr;
                    mem_write_data = cpu_wdata;
                    mem_write      = cpu_we;
                    mem_read       = ~cpu_we;
                    if (!cpu_we) cpu_rdata = mem_read_data;
                end
            end
            default: ;
        endcase
    end

    // Datapath next values: sweep address, starvation counter, DMA read response.
    always_comb begin
        clr_addr_d   = '0;
        starve_cnt_d = '0;
        dma_rvalid_d = 1'b0;
        dma_rdata_d  = dma_rdata_q;
        if (state_q == ST_CLEAR) begin
            if (clr_addr_q != LAST_ADDR) clr_addr_d = clr_addr_q + 1'b1;
        end else begin
            // A waiting DMA accumulates; a new sweep starts the count fresh.
            if (dma_valid && !grant_dma && !clear_start)
                starve_cnt_d = (starve_cnt_q == 8'hFF) ? 8'hFF : starve_cnt_q + 8'd1;
            if (grant_dma && !dma_we) begin
                dma_rvalid_d = 1'b1;
                dma_rdata_d  = mem_read_data;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            clr_addr_q   <= '0;
            starve_cnt_q <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            clr_addr_q   <= clr_addr_d;
            starve_cnt_q <= starve_cnt_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: counts pipeline stalls in RUN, restarts with a commanded sweep.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_RUN) begin
            if (clear_start)
                stall_cnt_d = '0;
            else if (cpu_stall && stall_cnt_q != 16'hFFFF)
                stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test-plan sequences plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int AW    = 8;
    localparam int MSIZE = 256;
    localparam int SLIM  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_valid, dma_we, clear_start;
    logic [AW-1:0] cpu_addr, dma_addr, mem_address;
    logic [7:0]    cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, mem_write_data, mem_read_data;
    logic          cpu_stall, dma_ready, dma_rvalid, clear_busy, mem_write, mem_read;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0]   stall_count;
`endif

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDRESS_LINE(AW), .MEM_SIZE(MSIZE), .STARVE_LIMIT(SLIM)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .clear_start(clear_start), .clear_busy(clear_busy),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
`ifdef DMEM_ARB_PERF_EN
        , .stall_count(stall_count)
`endif
    );

    // Physical memory seen by the DUT.
    logic [7:0] ram [MSIZE];
    assign mem_read_data = ram[mem_address];
    always @(posedge clock) if (mem_write) ram[mem_address] <= mem_write_data;

    // Reference model state.
    logic [7:0] ref_mem [MSIZE];
    int         clear_left;
    int         waited;
    bit         pend;
    logic [7:0] exp_rdata;
    bit         last_stall, last_gd;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cyc(input bit rst, input bit cs, input bit cr, input bit cw,
                       input logic [7:0] ca, input logic [7:0] cd, input bit dv,
                       input bit dw, input logic [7:0] da, input logic [7:0] dd,
                       input bit do_chk);
        bit gd, gc, e_mw, e_mr;
        logic [7:0] e_addr, e_wd, e_crd;
        @(negedge clock);
        reset = rst; clear_start = cs;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_valid = dv; dma_we = dw; dma_addr = da; dma_wdata = dd;
        #1;
        gd = 0; gc = 0; e_mw = 0; e_mr = 0; e_addr = 0; e_wd = 0; e_crd = 0;
        if (clear_left > 0) begin
            e_mw   = 1;
            e_addr = 8'(MSIZE - clear_left);
        end else begin
            gd = dv && (!cr || waited >= SLIM);
            gc = cr && !gd;
            if (gd) begin
                e_addr = da; e_wd = dd; e_mw = dw; e_mr = !dw;
            end else if (gc) begin
                e_addr = ca; e_wd = cd; e_mw = cw; e_mr = !cw;
                if (!cw) e_crd = ref_mem[ca];
            end
        end
        if (do_chk) begin
            chk("clear_busy", clear_busy, clear_left > 0);
            chk("cpu_stall", cpu_stall, cr && !gc);
            chk("dma_ready", dma_ready, gd);
            chk("mem_write", mem_write, e_mw);
            chk("mem_read", mem_read, e_mr);
            chk("mem_address", mem_address, e_addr);
            chk("mem_write_data", mem_write_data, e_wd);
            chk("cpu_rdata", cpu_rdata, e_crd);
            chk("dma_rvalid", dma_rvalid, pend);
            chk("dma_rdata", dma_rdata, exp_rdata);
        end
        // advance model
        last_stall = cr && !gc;
        last_gd    = gd;
        pend       = gd && !dw;
        if (gd && !dw) exp_rdata = ref_mem[da];
        if (e_mw) ref_mem[e_addr] = e_wd;
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (dv && !gd) waited = (waited >= 255) ? 255 : waited + 1;
            else           waited = 0;
            if (cs) begin
                clear_left = MSIZE;
                waited     = 0;
            end
        end
        if (rst) begin
            clear_left = MSIZE; waited = 0; pend = 0; exp_rdata = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bit       hc, hd, r, c, cr, cw, dv, dw;
        logic [7:0] ca, cd, da, dd;
        for (int i = 0; i < MSIZE; i++) ref_mem[i] = 8'hxx;
        clear_left = MSIZE; waited = 0; pend = 0; exp_rdata = 0;

        // Reset, then the full sweep followed by idle RUN.
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(MSIZE + 4);

        // CPU write then read of 0x10.
        cyc(0, 0, 1, 1, 8'h10, 8'h5A, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 8'h10, 8'h00, 0, 0, 0, 0, 1);
        chk("plan_cpu_rd", cpu_rdata, 8'h5A);

        // DMA read of 0x10 with CPU idle.
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 8'h10, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("plan_dma_rd", dma_rdata, 8'h5A);

        // Both requesting continuously: DMA forced in after the starvation limit.
        for (int i = 0; i < 14; i++)
            cyc(0, 0, 1, 1, 8'(8'h40 + i), 8'(i), 1, 1, 8'h80, 8'h77, 1);
        idle(2);

        // clear_start during a DMA write of 0x33 to 0x20, then read back after sweep.
        cyc(0, 1, 0, 0, 0, 0, 1, 1, 8'h20, 8'h33, 1);
        idle(MSIZE + 2);
        cyc(0, 0, 1, 0, 8'h20, 0, 0, 0, 0, 0, 1);
        chk("plan_after_clear", cpu_rdata, 8'h00);

        // Reset at sweep cycle 100 restarts the sweep.
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(100);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(MSIZE + 2);

        // Random traffic with requesters holding stalled/unaccepted requests.
        hc = 0; hd = 0;
        cr = 0; cw = 0; ca = 0; cd = 0; dv = 0; dw = 0; da = 0; dd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hc) begin
                cr = ($urandom_range(0, 9) < 6);
                cw = $urandom_range(0, 1) == 1;
                ca = 8'($urandom_range(0, 31));
                cd = 8'($urandom);
            end
            if (!hd) begin
                dv = ($urandom_range(0, 9) < 4);
                dw = $urandom_range(0, 1) == 1;
                da = 8'($urandom_range(0, 31));
                dd = 8'($urandom);
            end
            r = ($urandom_range(0, 999) == 0);
            c = ($urandom_range(0, 399) == 0);
            cyc(r, c, cr, cw, ca, cd, dv, dw, da, dd, 1);
            hc = cr && last_stall && !r;
            hd = dv && !last_gd && !r;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
